// File: rtl/alu_logic_pkg.sv
// rtl/alu_logic_pkg.sv - shared op encodings, FSM states and sizing helper for the serial logic unit
package alu_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Slice index needs at least one bit even when a single slice covers the word.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_slice.sv
// rtl/logic_slice.sv - combinational bitwise AND/OR/XOR/NOR over one slice
module logic_slice
    import alu_logic_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  op_e              op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_serial_unit.sv
// rtl/bitwise_serial_unit.sv - slice-serial bitwise logic unit with valid/ready handshakes
module bitwise_serial_unit
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_cfg
            $error("bitwise_serial_unit: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_e           state;
    state_e           state_next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_e              op_q;
    logic [SLICE-1:0] y;
    logic [WIDTH-1:0] result_next;
    int               base;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign base      = int'(idx) * SLICE;

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_q),
        .a  (a_q[base +: SLICE]),
        .b  (b_q[base +: SLICE]),
        .y  (y)
    );

    // Full word with the current slice merged in, so zero can see the final slice on the last edge.
    always_comb begin
        result_next = result;
        result_next[base +: SLICE] = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = ST_RUN;
            ST_RUN:  if (idx == LAST_IDX) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_AND;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op_e'(op);
                        idx  <= '0;
                    end
                end
                ST_RUN: begin
                    result <= result_next;
                    if (idx == LAST_IDX) begin
                        zero <= (result_next == '0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_serial_unit.sv
// tb/tb_bitwise_serial_unit.sv - directed self-checking bench for bitwise_serial_unit
module tb_bitwise_serial_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] result;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, zero1;
    logic [31:0] result1;

    int n_checks;
    int n_fail;

    bitwise_serial_unit #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    bitwise_serial_unit #(.WIDTH(32), .SLICE(32)) u_dut_wide (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .result    (result1),
        .zero      (zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept on the narrow unit, then confirm out_valid rises exactly on the 4th edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
        op = o; a = va; b = vb; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("in_ready_busy_%0d", k), {31'b0, in_ready}, 32'd0);
            step();
            check($sformatf("out_valid_c%0d", k), {31'b0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic handoff(input logic [31:0] exp_res);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("in_ready_after_handoff", {31'b0, in_ready}, 32'd1);
        check("out_valid_after_handoff", {31'b0, out_valid}, 32'd0);
        step();
        check("result_held_idle", result, exp_res);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
        out_ready = 1'b0; out_ready1 = 1'b0;
        op = 2'b00; a = '0; b = '0;
        #12;
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_in_ready_wide", {31'b0, in_ready1}, 32'd1);
        step();
        rst_n = 1'b1;
        step();

        run_op(2'b11, 32'h0000_0000, 32'h0000_0000);
        check("nor_result", result, 32'hFFFF_FFFF);
        check("nor_zero", {31'b0, zero}, 32'd0);
        handoff(32'hFFFF_FFFF);

        run_op(2'b10, 32'hA5A5_F00F, 32'hA5A5_F00F);
        check("xor_result", result, 32'h0000_0000);
        check("xor_zero", {31'b0, zero}, 32'd1);
        handoff(32'h0000_0000);

        // Operands and in_valid disturbed mid-flight must not leak into the result.
        op = 2'b00; a = 32'h1234_5678; b = 32'hFF00_FF00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        a = 32'h0; op = 2'b01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        check("and_out_valid", {31'b0, out_valid}, 32'd1);
        check("and_result", result, 32'h1200_5600);
        check("and_zero", {31'b0, zero}, 32'd0);
        handoff(32'h1200_5600);

        run_op(2'b01, 32'h0000_FFFF, 32'hFFFF_0000);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("or_hold_result_%0d", k), result, 32'hFFFF_FFFF);
            check($sformatf("or_hold_valid_%0d", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("or_hold_in_ready_%0d", k), {31'b0, in_ready}, 32'd0);
            step();
        end
        handoff(32'hFFFF_FFFF);

        op = 2'b10; a = 32'h1111_1111; b = 32'h2222_2222; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("abort_no_valid_%0d", k), {31'b0, out_valid}, 32'd0);
        end
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0000);
        check("post_rst_nor_result", result, 32'h0000_0000);
        check("post_rst_nor_zero", {31'b0, zero}, 32'd1);
        handoff(32'h0000_0000);

        op = 2'b11; a = 32'h0F0F_0F0F; b = 32'h00FF_00FF; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        check("wide_in_ready_busy", {31'b0, in_ready1}, 32'd0);
        check("wide_no_early_valid", {31'b0, out_valid1}, 32'd0);
        step();
        check("wide_out_valid", {31'b0, out_valid1}, 32'd1);
        check("wide_result", result1, 32'hF000_F000);
        check("wide_zero", {31'b0, zero1}, 32'd0);
        check("narrow_idle_untouched", {31'b0, in_ready}, 32'd1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("wide_in_ready_after", {31'b0, in_ready1}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitwise_serial_unit.md
BITWISE_SERIAL_UNIT -- requirements
Module: bitwise_serial_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter SLICE, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, otherwise elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands and op are valid.
REQ-006 in_ready  output  1  unit can accept operands.
REQ-007 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result and zero are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  bitwise result, registered.
REQ-013 zero  output  1  registered; 1 when result equals 0.

Function
REQ-014 Three states: IDLE, RUN, DONE; N = WIDTH/SLICE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are decoded from state only.
REQ-016 IDLE: on an edge with in_valid=1, capture a, b and op, clear slice index to 0, and go to RUN; otherwise stay in IDLE.
REQ-017 RUN: each edge writes result[idx*SLICE +: SLICE] = op(a, b) for that slice, LSB slice first, then increments idx.
REQ-018 RUN: the edge that writes slice N-1 SHALL go to DONE and register zero from the complete result.
REQ-019 Latency: out_valid SHALL first be 1 exactly N cycles after the accept edge; SLICE=WIDTH gives 1 cycle.
REQ-020 DONE: result, zero and out_valid SHALL hold stable until an edge with out_ready=1, which SHALL go to IDLE.
REQ-021 A new accept SHALL NOT occur on the same edge as a result handoff; throughput is one operation per N+2 cycles.
REQ-022 Operand, op and in_valid changes after acceptance SHALL NOT affect the operation in flight.
REQ-023 In IDLE, result and zero SHALL keep the last delivered values.
REQ-024 Slice index width SHALL be clog2(N), minimum 1; it SHALL NOT wrap within an operation.

Reset
REQ-025 While rst_n=0: state IDLE, idx 0, result 0, zero 0, out_valid 0, in_ready 1.
REQ-026 Asserting reset in RUN or DONE SHALL abandon the operation immediately; no out_valid pulse SHALL follow.
REQ-027 The first accept after release SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-028 The op encodings and the state enum SHALL live in the shared package alu_logic_pkg.
REQ-029 A combinational sub-module logic_slice (width SLICE, inputs op, a, b, output y) SHALL perform the per-slice operation, instantiated once.

Verification
REQ-030 Use WIDTH=32, SLICE=8. NOR with a=0x00000000, b=0x00000000 -> result 0xFFFFFFFF, zero=0, out_valid first high 4 cycles after accept.
REQ-031 XOR with a=0xA5A5F00F, b=0xA5A5F00F -> result 0x00000000, zero=1.
REQ-032 AND with a=0x12345678, b=0xFF00FF00; change a to 0 during RUN -> result 0x12005600.
REQ-033 OR with a=0x0000FFFF, b=0xFFFF0000; hold out_ready=0 for 5 cycles -> result 0xFFFFFFFF stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
REQ-034 Assert rst_n=0 after 2 RUN cycles -> result 0, out_valid never pulses, in_ready=1; a following NOR of 0xFFFFFFFF and 0 -> result 0x00000000, zero=1.
REQ-035 SLICE=32, NOR with a=0x0F0F0F0F, b=0x00FF00FF -> result 0xF000F000, out_valid 1 cycle after accept.
